hazard_scoreboard: RTL

- Parametrised Tnew/Tuse hazard unit that sits beside the D-stage decoder.
- Tracks each in-flight instruction's destination register and result readiness through PIPE_DEPTH stages after D.
- Each cycle it produces a D-stage stall, per-operand forwarding selects, and multiply/divide busy tracking.
- Replaces per-stage "register read required" checks with one scoreboard shared by every stage configuration.

---
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard beside the D-stage decoder: tracks destination
// registers and result readiness through the stages after D, plus mul/div busy.

module hazard_operand #(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int T_W        = 2,
  parameter int FW         = $clog2(PIPE_DEPTH+1)
) (
  input  logic                                 req,
  input  logic [REG_ADDR_W-1:0]                src,
  input  logic [T_W-1:0]                       tuse,
  input  logic [PIPE_DEPTH:1][REG_ADDR_W-1:0]  dst,
  input  logic [PIPE_DEPTH:1][T_W-1:0]         rem,
  output logic                                 hazard,
  output logic [FW-1:0]                        sel
);
  logic           hit;
  logic [T_W-1:0] hit_rem;
  logic [FW-1:0]  hit_k;

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    hit     = 1'b0;
    hit_rem = '0;
    hit_k   = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (req && (src != '0) && (src == dst[k])) begin
        hit     = 1'b1;
        hit_rem = rem[k];
        hit_k   = FW'(k);
      end
    end
    hazard = hit && (hit_rem > tuse);
    sel    = (hit && (hit_rem == '0)) ? hit_k : '0;
  end
endmodule

module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int T_W        = 2,
  parameter int MUL_LAT    = 5,
  parameter int DIV_LAT    = 10,
  parameter int FW         = $clog2(PIPE_DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_rs,
  input  logic                  d_rs_req,
  input  logic [T_W-1:0]        d_rs_tuse,
  input  logic [REG_ADDR_W-1:0] d_rt,
  input  logic                  d_rt_req,
  input  logic [T_W-1:0]        d_rt_tuse,
  input  logic [REG_ADDR_W-1:0] d_dst,
  input  logic [T_W-1:0]        d_tnew,
  input  logic [1:0]            d_md_op,
  output logic                  stall,
  output logic [FW-1:0]         fwd_rs_sel,
  output logic [FW-1:0]         fwd_rt_sel,
  output logic                  md_busy,
  output logic                  md_start
);
  localparam int CW = $clog2(DIV_LAT+1);

  logic [PIPE_DEPTH:1][REG_ADDR_W-1:0] dst;
  logic [PIPE_DEPTH:1][T_W-1:0]        rem;
  logic [CW-1:0]                       md_cnt;

  logic [1:0][REG_ADDR_W-1:0] op_src;
  logic [1:0]                 op_req;
  logic [1:0][T_W-1:0]        op_tuse;
  logic [1:0]                 op_haz;
  logic [1:0][FW-1:0]         op_sel;

  assign op_src  = {d_rt, d_rs};
  assign op_req  = {d_rt_req, d_rs_req};
  assign op_tuse = {d_rt_tuse, d_rs_tuse};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_op
      hazard_operand #(
        .REG_ADDR_W(REG_ADDR_W), .PIPE_DEPTH(PIPE_DEPTH), .T_W(T_W), .FW(FW)
      ) u_op (
        .req   (op_req[g]),
        .src   (op_src[g]),
        .tuse  (op_tuse[g]),
        .dst   (dst),
        .rem   (rem),
        .hazard(op_haz[g]),
        .sel   (op_sel[g])
      );
    end
  endgenerate

  logic md_stall, issue, md_issue;

  assign md_stall   = (d_md_op != 2'b00) && (md_cnt != '0);
  assign stall      = d_valid && (op_haz[0] || op_haz[1] || md_stall);
  assign issue      = d_valid && !stall;
  // The reset gate keeps md_start low while reset is held with a mul/div in D.
  assign md_issue   = issue && !reset && (d_md_op[0] ^ d_md_op[1]);
  assign md_start   = md_issue;
  assign md_busy    = (md_cnt != '0);
  assign fwd_rs_sel = op_sel[0];
  assign fwd_rt_sel = op_sel[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst    <= '0;
      rem    <= '0;
      md_cnt <= '0;
    end else begin
      dst[1] <= issue ? d_dst  : '0;
      rem[1] <= issue ? d_tnew : '0;
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        dst[k] <= dst[k-1];
        rem[k] <= (rem[k-1] == '0) ? '0 : rem[k-1] - 1'b1;
      end
      if (md_issue)
        md_cnt <= (d_md_op == 2'b01) ? CW'(MUL_LAT) : CW'(DIV_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end
endmodule
